// File: rtl/adder_sequencer.sv
// adder_sequencer: push-button controlled W-bit adder that reuses one external
// 4-bit combinational slice adder over NIBBLES cycles with a registered carry.
module adder_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   LoadB,
  input  logic                   Run,
  input  logic [4*NIBBLES-1:0]   SW,
  input  logic [3:0]             slice_s,
  input  logic                   slice_co,
  output logic [3:0]             slice_a,
  output logic [3:0]             slice_b,
  output logic                   slice_ci,
  output logic [4*NIBBLES-1:0]   A_out,
  output logic [4*NIBBLES-1:0]   B_out,
  output logic [4*NIBBLES-1:0]   Sum,
  output logic                   CO,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             dbg_state
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      loadb_sync_q, run_sync_q;
  logic            loadb_prev_q, run_prev_q;
  logic            loadb_ev, run_ev, run_released;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d, part_q, part_d;
  logic            co_q, co_d, carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Buttons are active-low: an event is the synchronized level falling.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      loadb_sync_q <= 2'b11;
      run_sync_q   <= 2'b11;
      loadb_prev_q <= 1'b1;
      run_prev_q   <= 1'b1;
    end else begin
      loadb_sync_q <= {loadb_sync_q[0], LoadB};
      run_sync_q   <= {run_sync_q[0], Run};
      loadb_prev_q <= loadb_sync_q[1];
      run_prev_q   <= run_sync_q[1];
    end
  end

  assign loadb_ev     = !loadb_sync_q[1] && loadb_prev_q;
  assign run_ev       = !run_sync_q[1] && run_prev_q;
  assign run_released = run_sync_q[1];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (run_ev) state_d = COMPUTE;
      COMPUTE: if (cnt_q == LAST) state_d = DONE;
      DONE:    if (run_released) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    slice_a  = 4'd0;
    slice_b  = 4'd0;
    slice_ci = 1'b0;
    case (state_q)
      COMPUTE: begin
        busy     = 1'b1;
        slice_a  = a_q[4*cnt_q +: 4];
        slice_b  = b_q[4*cnt_q +: 4];
        slice_ci = carry_q;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Sum/CO only move on the final nibble so the display holds the last result.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    co_d    = co_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    case (state_q)
      IDLE: begin
        if (loadb_ev) b_d = SW;
        if (run_ev) begin
          a_d     = SW;
          carry_d = 1'b0;
          cnt_d   = '0;
        end
      end
      COMPUTE: begin
        part_d[4*cnt_q +: 4] = slice_s;
        carry_d = slice_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d = part_d;
          co_d  = slice_co;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      part_q  <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
    end
  end

  assign A_out     = a_q;
  assign B_out     = b_q;
  assign Sum       = sum_q;
  assign CO        = co_q;
  assign dbg_state = state_q;

endmodule
